// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one combinational compare unit between NUM_REQ requesters.
//
// A round-robin arbiter grants at most one request per cycle. The granted
// operands are registered into a one-deep issue stage that drives the compare
// unit. On the following edge the unit's n/z/sn flags are captured into the
// owning requester's response slot. Each slot holds its response until the
// requester takes it with rsp_ready.
//
// Configuration macro:
//   CMP_ARB_PRIO0_EN  defined: requester 0 has strict priority and does not
//                     move the rr pointer; 1..NUM_REQ-1 share round-robin.
//                     undefined (default): pure round-robin over all requesters.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester request handshake
//   req_a/req_b            packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready    per-requester response handshake
//   rsp_n/rsp_z/rsp_sn     per-slot unsigned-less, equal, signed-less flags
//   cmp_en                 issue stage valid (compare unit opcode enable)
//   cmp_arg0/cmp_arg1      registered operands to the compare unit
//   cmp_n/cmp_z/cmp_sn     flags returned by the compare unit
//   busy                   any slot occupied or issue stage valid

module cmp_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [NUM_REQ-1:0]         rsp_n,
  output logic [NUM_REQ-1:0]         rsp_z,
  output logic [NUM_REQ-1:0]         rsp_sn,
  output logic                       cmp_en,
  output logic [WIDTH-1:0]           cmp_arg0,
  output logic [WIDTH-1:0]           cmp_arg1,
  input  logic                       cmp_n,
  input  logic                       cmp_z,
  input  logic                       cmp_sn,
  output logic                       busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_PEND = 2'd1,
    SLOT_DONE = 2'd2
  } slot_state_e;

  slot_state_e              slot_q [NUM_REQ];
  slot_state_e              slot_d [NUM_REQ];
  logic [PTR_W-1:0]         rr_q, rr_d;
  logic                     issue_vld_q, issue_vld_d;
  logic [PTR_W-1:0]         owner_q, owner_d;
  logic [WIDTH-1:0]         arg0_q, arg0_d;
  logic [WIDTH-1:0]         arg1_q, arg1_d;
  logic [NUM_REQ-1:0]       rsp_n_q, rsp_n_d;
  logic [NUM_REQ-1:0]       rsp_z_q, rsp_z_d;
  logic [NUM_REQ-1:0]       rsp_sn_q, rsp_sn_d;
  logic                     busy_q, busy_d;

  logic [NUM_REQ-1:0]       eligible_c;
  logic [NUM_REQ-1:0]       grant_c;
  logic                     grant_vld_c;
  logic [PTR_W-1:0]         grant_idx_c;
  logic [PTR_W-1:0]         grant_next_c;
  logic [WIDTH-1:0]         a_arr [NUM_REQ];
  logic [WIDTH-1:0]         b_arr [NUM_REQ];

  // Unpack the flat operand buses into per-requester views.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // A requester can only be granted while its slot is free.
  always_comb begin
    eligible_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible_c[i] = req_valid[i] && (slot_q[i] == SLOT_IDLE);
    end
  end

  // Pick the first eligible index at or after the rr pointer.
  always_comb begin : arb_pick
    logic [PTR_W-1:0] cand;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    cand        = '0;
`ifdef CMP_ARB_PRIO0_EN
    if (eligible_c[0]) begin
      grant_vld_c = 1'b1;
      grant_idx_c = '0;
    end else begin
      // Index 0 is skipped here; it only ever wins through the priority path.
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        cand = PTR_W'((32'(rr_q) + j) % NUM_REQ);
        if (!grant_vld_c && (cand != '0) && eligible_c[cand]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = cand;
        end
      end
    end
`else
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      cand = PTR_W'((32'(rr_q) + j) % NUM_REQ);
      if (!grant_vld_c && eligible_c[cand]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = cand;
      end
    end
`endif
  end

  // One-hot grant; a grant is exactly the accept for that requester.
  always_comb begin
    grant_c = '0;
    if (grant_vld_c) begin
      grant_c[grant_idx_c] = 1'b1;
    end
  end

  assign req_ready = grant_c;

  // Pointer moves to the slot after the winner, wrapping at NUM_REQ.
  always_comb begin
    grant_next_c = (32'(grant_idx_c) == NUM_REQ - 1) ? '0 : grant_idx_c + PTR_W'(1);
    rr_d = rr_q;
    if (grant_vld_c) begin
`ifdef CMP_ARB_PRIO0_EN
      if (grant_idx_c != '0) begin
        rr_d = grant_next_c;
      end
`else
      rr_d = grant_next_c;
`endif
    end
  end

  // Issue stage: always drains in one cycle; args hold when idle.
  always_comb begin
    issue_vld_d = grant_vld_c;
    owner_d     = owner_q;
    arg0_d      = arg0_q;
    arg1_d      = arg1_q;
    if (grant_vld_c) begin
      owner_d = grant_idx_c;
      arg0_d  = a_arr[grant_idx_c];
      arg1_d  = b_arr[grant_idx_c];
    end
  end

  // Per-slot state machine and response capture.
  always_comb begin
    rsp_n_d  = rsp_n_q;
    rsp_z_d  = rsp_z_q;
    rsp_sn_d = rsp_sn_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        SLOT_IDLE: begin
          if (grant_c[i]) begin
            slot_d[i] = SLOT_PEND;
          end
        end
        SLOT_PEND: begin
          // The issue stage is single-cycle, so the owner match lands on
          // the first edge after the accept.
          if (issue_vld_q && (owner_q == PTR_W'(i))) begin
            slot_d[i]   = SLOT_DONE;
            rsp_n_d[i]  = cmp_n;
            rsp_z_d[i]  = cmp_z;
            rsp_sn_d[i] = cmp_sn;
          end
        end
        SLOT_DONE: begin
          if (rsp_ready[i]) begin
            slot_d[i] = SLOT_IDLE;
          end
        end
        default: begin
          slot_d[i] = SLOT_IDLE;
        end
      endcase
    end
  end

  // Busy reflects the state that will be held after this edge.
  always_comb begin
    busy_d = issue_vld_d;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (slot_d[i] != SLOT_IDLE) begin
        busy_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= SLOT_IDLE;
      end
      rr_q        <= '0;
      issue_vld_q <= 1'b0;
      owner_q     <= '0;
      arg0_q      <= '0;
      arg1_q      <= '0;
      rsp_n_q     <= '0;
      rsp_z_q     <= '0;
      rsp_sn_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= slot_d[i];
      end
      rr_q        <= rr_d;
      issue_vld_q <= issue_vld_d;
      owner_q     <= owner_d;
      arg0_q      <= arg0_d;
      arg1_q      <= arg1_d;
      rsp_n_q     <= rsp_n_d;
      rsp_z_q     <= rsp_z_d;
      rsp_sn_q    <= rsp_sn_d;
      busy_q      <= busy_d;
    end
  end

  // Response valid is a direct decode of the slot register.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (slot_q[i] == SLOT_DONE);
    end
  end

  assign rsp_n    = rsp_n_q;
  assign rsp_z    = rsp_z_q;
  assign rsp_sn   = rsp_sn_q;
  assign cmp_en   = issue_vld_q;
  assign cmp_arg0 = arg0_q;
  assign cmp_arg1 = arg1_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed testbench for cmp_arbiter with a behavioural compare unit.
module tb_cmp_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 64;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_a;
  logic [NR*W-1:0]   req_b;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [NR-1:0]     rsp_n;
  logic [NR-1:0]     rsp_z;
  logic [NR-1:0]     rsp_sn;
  logic              cmp_en;
  logic [W-1:0]      cmp_arg0;
  logic [W-1:0]      cmp_arg1;
  logic              cmp_n;
  logic              cmp_z;
  logic              cmp_sn;
  logic              busy;

  int unsigned n_vec;
  int unsigned n_err;

  cmp_arbiter #(.NUM_REQ(NR), .WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_n     (rsp_n),
    .rsp_z     (rsp_z),
    .rsp_sn    (rsp_sn),
    .cmp_en    (cmp_en),
    .cmp_arg0  (cmp_arg0),
    .cmp_arg1  (cmp_arg1),
    .cmp_n     (cmp_n),
    .cmp_z     (cmp_z),
    .cmp_sn    (cmp_sn),
    .busy      (busy)
  );

  // Behavioural stand-in for the shared compare unit.
  assign cmp_n  = (cmp_arg0 < cmp_arg1);
  assign cmp_z  = (cmp_arg0 == cmp_arg1);
  assign cmp_sn = ($signed(cmp_arg0) < $signed(cmp_arg1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int k, input logic [63:0] a, input logic [63:0] b);
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
  endtask

  // Single request on requester k, full round trip with flag checks.
  task automatic run_one(input int k, input logic [63:0] a, input logic [63:0] b,
                         input logic en, input logic ez, input logic esn, input string tag);
    set_ops(k, a, b);
    req_valid    = '0;
    req_valid[k] = 1'b1;
    #1;
    chk({tag, "_ready"}, 64'(req_ready[k]), 64'd1);
    step();
    req_valid = '0;
    step();
    chk({tag, "_valid"}, 64'(rsp_valid[k]), 64'd1);
    chk({tag, "_n"},     64'(rsp_n[k]),     64'(en));
    chk({tag, "_z"},     64'(rsp_z[k]),     64'(ez));
    chk({tag, "_sn"},    64'(rsp_sn[k]),    64'(esn));
    rsp_ready[k] = 1'b1;
    step();
    rsp_ready = '0;
    chk({tag, "_release"}, 64'(rsp_valid[k]), 64'd0);
  endtask

  logic [63:0] ca [NR];
  logic [63:0] cb [NR];
  int unsigned completions;
  int unsigned done_now;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;

    // Reset state
    #2;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_flags",     64'({rsp_n, rsp_z, rsp_sn}), 64'd0);
    chk("rst_cmp_en",    64'(cmp_en), 64'd0);
    chk("rst_args",      64'(cmp_arg0 | cmp_arg1), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic: 5 vs 7, two-cycle latency, no re-accept while DONE
    set_ops(0, 64'd5, 64'd7);
    req_valid = 4'b0001;
    #1;
    chk("b_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    chk("b_cmp_en", 64'(cmp_en), 64'd1);
    chk("b_arg0",   cmp_arg0, 64'd5);
    chk("b_arg1",   cmp_arg1, 64'd7);
    chk("b_early",  64'(rsp_valid), 64'd0);
    chk("b_busy",   64'(busy), 64'd1);
    step();
    chk("b_valid", 64'(rsp_valid), 64'b0001);
    chk("b_flags", 64'({rsp_n[0], rsp_z[0], rsp_sn[0]}), 64'b101);
    req_valid = 4'b0001;
    #1;
    chk("b_held_ready", 64'(req_ready), 64'd0);
    step();
    chk("b_hold_valid", 64'(rsp_valid), 64'b0001);
    chk("b_hold_en",    64'(cmp_en), 64'd0);
    rsp_ready = 4'b0001;
    #1;
    chk("b_same_cycle_ready", 64'(req_ready), 64'd0);
    step();
    rsp_ready = '0;
    #1;
    chk("b_freed_valid", 64'(rsp_valid), 64'd0);
    chk("b_freed_ready", 64'(req_ready), 64'b0001);
    req_valid = '0;

    // Signed vs unsigned corners
    run_one(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1, "neg1");
    run_one(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, "min_eq");
    // Requester 3 also moves the pointer back to 0
    run_one(3, 64'd10, 64'd2, 1'b0, 1'b0, 1'b0, "r3");

    // Contention: all four at once, pointer at 0
    ca[0] = 64'd1;                  cb[0] = 64'd2;
    ca[1] = 64'd2;                  cb[1] = 64'd2;
    ca[2] = 64'hFFFF_FFFF_FFFF_FFFF; cb[2] = 64'd0;
    ca[3] = 64'h7FFF_FFFF_FFFF_FFFF; cb[3] = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 4; i++) set_ops(i, ca[i], cb[i]);
    req_valid = 4'b1111;
    #1;
    chk("c_ready0", 64'(req_ready), 64'b0001);
    step();
    chk("c_arg0_0", cmp_arg0, ca[0]);
    chk("c_ready1", 64'(req_ready), 64'b0010);
    step();
    chk("c_valid1", 64'(rsp_valid), 64'b0001);
    chk("c_ready2", 64'(req_ready), 64'b0100);
    chk("c_arg0_1", cmp_arg0, ca[1]);
    step();
    chk("c_valid2", 64'(rsp_valid), 64'b0011);
    chk("c_ready3", 64'(req_ready), 64'b1000);
    step();
    chk("c_valid3", 64'(rsp_valid), 64'b0111);
    chk("c_ready4", 64'(req_ready), 64'b0000);
    chk("c_arg0_3", cmp_arg0, ca[3]);
    step();
    chk("c_valid4", 64'(rsp_valid), 64'b1111);
    chk("c_en_off", 64'(cmp_en), 64'd0);
    chk("c_n",      64'(rsp_n),  64'b1001);
    chk("c_z",      64'(rsp_z),  64'b0010);
    chk("c_sn",     64'(rsp_sn), 64'b0101);
    rsp_ready = 4'b1111;
    step();
    rsp_ready = '0;
    #1;
    chk("c_drained", 64'(rsp_valid), 64'd0);
    chk("c_ptr0",    64'(req_ready), 64'b0001);
    req_valid = '0;
    #1;

    // Backpressure on slot 1 while 0,2,3 stream
    set_ops(1, 64'd3, 64'd3);
    req_valid = 4'b0010;
    #1;
    chk("bp_ready1", 64'(req_ready), 64'b0010);
    step();
    step();
    chk("bp_valid1", 64'(rsp_valid[1]), 64'd1);
    chk("bp_flags1", 64'({rsp_n[1], rsp_z[1], rsp_sn[1]}), 64'b010);
    for (int i = 0; i < 4; i++) if (i != 1) set_ops(i, 64'd0, 64'd5);
    req_valid   = 4'b1111;
    rsp_ready   = 4'b1101;
    completions = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      done_now = 0;
      for (int i = 0; i < 4; i++) if (i != 1 && rsp_valid[i] && rsp_ready[i]) done_now++;
      completions += done_now;
      chk($sformatf("bp_hold_c%0d", c),
          64'({rsp_valid[1], rsp_n[1], rsp_z[1], rsp_sn[1], req_ready[1]}), 64'b10100);
      chk($sformatf("bp_en_c%0d", c), 64'(cmp_en), (c != 0) ? 64'd1 : 64'd0);
      chk($sformatf("bp_done_c%0d", c), 64'(done_now), (c >= 2) ? 64'd1 : 64'd0);
      step();
    end
    chk("bp_total", 64'(completions), 64'd8);
    req_valid = '0;
    rsp_ready = 4'b1111;
    step();
    step();
    step();
    rsp_ready = '0;
    chk("bp_idle_busy",  64'(busy), 64'd0);
    chk("bp_idle_valid", 64'(rsp_valid), 64'd0);

    // Reset with three compares in flight / held
    set_ops(0, 64'h55, 64'h66);
    req_valid = 4'b0111;
    step();
    step();
    step();
    chk("rm_busy_pre", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_valid", 64'(rsp_valid), 64'd0);
    chk("rm_en",    64'(cmp_en), 64'd0);
    chk("rm_busy",  64'(busy), 64'd0);
    chk("rm_arg0",  cmp_arg0, 64'd0);
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("rm_first_grant", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    chk("rm_first_arg", cmp_arg0, 64'h55);
    chk("rm_no_stale",  64'(rsp_valid), 64'd0);
    rsp_ready = 4'b1111;
    step();
    step();
    step();
    rsp_ready = '0;

`ifdef CMP_ARB_PRIO0_EN
    // Requester 0 wins whenever its slot is free; 2 only fills the gaps
    req_valid = 4'b0101;
    rsp_ready = 4'b0101;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk($sformatf("p0_ready_c%0d", c), 64'(req_ready),
          (c % 3 == 0) ? 64'b0001 : ((c % 3 == 1) ? 64'b0100 : 64'b0000));
      step();
    end
    req_valid = '0;
    step();
    step();
    rsp_ready = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one combinational `compare` datapath between NUM_REQ requesters, e.g. the integer pipe, branch unit and load/store address checks.
- Grants one request per cycle by round-robin and registers the operands into an issue stage.
- Drives the shared compare unit from that issue stage, then captures n/z/sn into a per-requester response slot.
- Each slot holds its response until the owning requester accepts it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 64, operand width in bits; matches the compare unit's ulong/long view.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester compare request.
- req_ready  output  NUM_REQ  request accepted this cycle; valid&&ready is the transfer.
- req_a  input  NUM_REQ*WIDTH  operand 0, requester i in bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand 1, same packing.
- rsp_valid  output  NUM_REQ  response slot i holds a result.
- rsp_ready  input  NUM_REQ  requester i consumes its result.
- rsp_n  output  NUM_REQ  unsigned less-than flag per slot.
- rsp_z  output  NUM_REQ  equal flag per slot.
- rsp_sn  output  NUM_REQ  signed less-than flag per slot.
- cmp_en  output  1  issue stage valid; the wrapper drives opcode CMP into the compare unit when high.
- cmp_arg0  output  WIDTH  registered operand 0 to the compare unit.
- cmp_arg1  output  WIDTH  registered operand 1 to the compare unit.
- cmp_n  input  1  n result from the compare unit (combinational from cmp_arg*).
- cmp_z  input  1  z result from the compare unit.
- cmp_sn  input  1  sn result from the compare unit.
- busy  output  1  any slot not IDLE, or issue stage valid.

Behaviour:
- Reset (async, rst_n low):
  - slot states IDLE; issue valid 0; rr pointer 0.
  - rsp_valid, rsp_n, rsp_z, rsp_sn all 0.
  - cmp_en 0; cmp_arg0 and cmp_arg1 0; busy 0.
- Reset mid-operation discards all in-flight and held results. Requesters must reissue; no partial response appears after reset deasserts.
- Per-slot FSM:
  - IDLE -> PEND on accept (req_valid[i] && req_ready[i]).
  - PEND -> DONE on the edge after issue; response captured from cmp_n/cmp_z/cmp_sn.
  - DONE -> IDLE on rsp_ready[i].
- req_ready[i] = slot i IDLE && granted[i]. At most one outstanding compare per requester.
- Arbitration (combinational):
  - Eligible = req_valid[i] && slot i IDLE.
  - Grant the first eligible index at or after the rr pointer, modulo NUM_REQ.
  - At most one grant per cycle.
  - On grant of k, the rr pointer becomes (k+1) mod NUM_REQ. With no grant the pointer holds.
- Issue stage:
  - On grant, latch req_a/req_b of k into cmp_arg0/cmp_arg1, set cmp_en=1 and record owner k.
  - With no grant, cmp_en goes 0 and the args hold their last value.
  - The issue stage always drains in one cycle, so throughput is one compare per cycle.
- Latency: accept at edge T; cmp_en high during cycle T..T+1; rsp_valid[k]=1 from edge T+1, visible in the cycle after T+1 (two cycles from request presentation).
- A DONE slot holds its flags stable while rsp_ready is 0. Backpressure on one slot never stalls others.
- Simultaneous rsp_ready[i] and req_valid[i] in the same cycle: the slot is not IDLE, so no accept that cycle. The new request is accepted the next cycle at the earliest.
- Flags are taken from the compare unit as produced: n = unsigned a<b, z = a==b, sn = signed a<b.

Optional Feature:
- Macro CMP_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. If eligible it is granted regardless of the rr pointer, and the pointer does not advance. Remaining requesters use round-robin among indices 1..NUM_REQ-1.
- Undefined: pure round-robin across all NUM_REQ requesters, as described above.

Test Plan:
- Basic unsigned/signed: req0 a=5, b=7 -> rsp_valid[0] two cycles later with n=1, z=0, sn=1; req_ready[0]=0 until rsp_ready[0].
- Signed vs unsigned: a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> n=0, z=0, sn=1. Then a=b=0x8000_0000_0000_0000 -> n=0, z=1, sn=0.
- Contention: all 4 raise req_valid at T with the rr pointer at 0 -> grants 0,1,2,3 on consecutive edges; rsp_valid rises one per cycle in that order; the pointer ends at 0.
- Backpressure: rsp_ready[1]=0 for 10 cycles after a result (a=3, b=3, z=1) -> flags hold stable and req_ready[1] stays 0. Requesters 0, 2, 3 keep completing at one per cycle.
- Reset mid-operation: drop rst_n while 3 requests are PEND/DONE -> all rsp_valid, cmp_en and busy go 0 immediately; after release the first new grant goes to requester 0.
- With CMP_ARB_PRIO0_EN defined: req0 held continuously with req2 valid -> req0 is granted every time its slot is IDLE, and req2 is granted only in cycles where slot 0 is busy.
